// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pkg
//  Description : Shared types and default sizes for the round-robin capture
//                arbiter (state encoding, requester count, word width).
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

    // Default number of requesters sharing the capture register
    localparam int c_NUM_REQ_DEFAULT = 4;
    // Default width of each requester word and of the captured word
    localparam int c_DATA_W_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OUTPUT  = 2'd2
    } arb_state_e;

endpackage : dff_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first active
//                request found searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ),
//                so the most recent winner has the lowest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dff_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEFAULT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] w_cand;

    // Scan from the farthest offset down to rr_ptr+1 so the nearest active
    // request after the pointer is the last (winning) assignment.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[w_cand]) begin
                valid = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/dff_rr_capture_arb.sv
`default_nettype none
// ============================================================================
//  Module      : dff_rr_capture_arb
//  Description : Round-robin arbiter in front of one shared capture register.
//                A granted requester is acknowledged for one CAPTURE cycle,
//                its word (X/Z bits forced to 0) is stored in dout and held
//                on a valid/ready handshake until downstream accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_rr_capture_arb
    import dff_pkg::*;
#(
    parameter  int NUM_REQ = c_NUM_REQ_DEFAULT,
    parameter  int DATA_W  = c_DATA_W_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         dout,
    output logic [ID_W-1:0]           owner,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      proto_err
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [DATA_W-1:0] r_dout;
    logic [ID_W-1:0]   r_owner;
    logic              r_out_valid;
    logic              r_proto_err;

    logic              w_pick_valid;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_grant_held;
    logic [DATA_W-1:0] w_grant_word;
    logic [DATA_W-1:0] w_words [NUM_REQ];

    // Any bit that is not a definite 1 (0, X or Z) is stored as 0; in
    // hardware this reduces to a plain copy.
    function automatic logic [DATA_W-1:0] sanitise(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < DATA_W; b++) begin
            r[b] = (w[b] === 1'b1);
        end
        return r;
    endfunction

    // Split the packed input bus into one word per requester
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_words[g] = din[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_grant_word = w_words[r_grant_id];
    assign w_grant_held = req[r_grant_id];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .index  (w_pick_id)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; CAPTURE always lasts exactly one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) w_state_next = CAPTURE;
            end
            CAPTURE: begin
                w_state_next = w_grant_held ? OUTPUT : IDLE;
            end
            OUTPUT: begin
                if (out_ready) w_state_next = w_pick_valid ? CAPTURE : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Grant, pointer, capture and handshake registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_dout      <= '0;
            r_owner     <= '0;
            r_out_valid <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) r_grant_id <= w_pick_id;
                end
                CAPTURE: begin
                    if (w_grant_held) begin
                        r_dout      <= sanitise(w_grant_word);
                        r_owner     <= r_grant_id;
                        r_out_valid <= 1'b1;
                        r_rr_ptr    <= r_grant_id;
                    end else begin
                        // Requester let go before its ack: nothing captured
                        r_proto_err <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        // Pointer already holds the owner, so the next pick
                        // starts just after the word being handed off
                        if (w_pick_valid) r_grant_id <= w_pick_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ack is decoded purely from registered state, never from req
    always_comb begin
        ack = '0;
        if (r_state == CAPTURE) ack[r_grant_id] = 1'b1;
    end

    assign dout      = r_dout;
    assign owner     = r_owner;
    assign out_valid = r_out_valid;
    assign proto_err = r_proto_err;

endmodule : dff_rr_capture_arb
`default_nettype wire

// File: tb/tb_dff_rr_capture_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_rr_capture_arb
//  Description : Directed self-checking bench for dff_rr_capture_arb with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dff_rr_capture_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      resetn;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] din;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         dout;
    logic [ID_W-1:0]           owner;
    logic                      out_valid;
    logic                      out_ready;
    logic                      proto_err;

    int n_pass;
    int n_total;

    dff_rr_capture_arb #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .dout      (dout),
        .owner     (owner),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] words [4];
    logic [7:0] dirty;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        resetn    = 1'b0;
        req       = '0;
        din       = '0;
        out_ready = 1'b0;
        words[0]  = 8'h10;
        words[1]  = 8'h21;
        words[2]  = 8'h32;
        words[3]  = 8'h43;

        // Reset values
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_dout",      32'(dout),      32'h0);
        check("rst_owner",     32'(owner),     32'h0);
        check("rst_ack",       32'(ack),       32'h0);
        check("rst_proto_err", 32'(proto_err), 32'h0);
        resetn = 1'b1;
        step();

        // All four requesting, downstream always ready: 0,1,2,3,0 one per 2 cycles
        din       = {words[3], words[2], words[1], words[0]};
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_ack",       32'(ack),       32'(4'b0001 << (k % 4)));
            check("rr_valid_lo",  32'(out_valid), 32'h0);
            step();
            check("rr_valid",     32'(out_valid), 32'h1);
            check("rr_owner",     32'(owner),     32'(k % 4));
            check("rr_dout",      32'(dout),      32'(words[k % 4]));
        end
        req = '0;
        step();
        check("rr_idle_valid", 32'(out_valid), 32'h0);

        // Backpressure: word held stable while out_ready is low
        din[23:16] = 8'hA5;
        req        = 4'b0100;
        out_ready  = 1'b0;
        step();
        check("bp_ack", 32'(ack), 32'h4);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_dout",  32'(dout),      32'hA5);
            check("bp_owner", 32'(owner),     32'h2);
            check("bp_ack0",  32'(ack),       32'h0);
            step();
        end
        req       = '0;
        out_ready = 1'b1;
        step();
        check("bp_drop_valid", 32'(out_valid), 32'h0);

        // X/Z bits are captured as 0
        dirty     = 8'b1x0z_1100;
        din[15:8] = dirty;
        req       = 4'b0010;
        step();
        check("xz_ack", 32'(ack), 32'h2);
        step();
        check("xz_dout",  32'(dout),  32'h8C);
        check("xz_owner", 32'(owner), 32'h1);
        req = '0;
        step();

        // Granted request dropped during CAPTURE: no capture, one proto_err pulse
        req = 4'b1000;
        step();
        check("pe_ack", 32'(ack), 32'h8);
        req = '0;
        step();
        check("pe_pulse",   32'(proto_err), 32'h1);
        check("pe_valid",   32'(out_valid), 32'h0);
        check("pe_dout",    32'(dout),      32'h8C);
        check("pe_owner",   32'(owner),     32'h1);
        check("pe_ack_idle",32'(ack),       32'h0);
        step();
        check("pe_pulse_end", 32'(proto_err), 32'h0);
        check("pe_stay_idle", 32'(ack),       32'h0);

        // Pointer rotation: after 0 wins, a newly raised 3 beats the held 0
        req       = 4'b0001;
        out_ready = 1'b1;
        step();
        check("rot_ack0", 32'(ack), 32'h1);
        step();
        check("rot_owner0", 32'(owner), 32'h0);
        req = 4'b1001;
        step();
        check("rot_ack3", 32'(ack), 32'h8);
        step();
        check("rot_owner3", 32'(owner), 32'h3);
        check("rot_dout3",  32'(dout),  32'h43);
        step();
        check("rot_ack0_again", 32'(ack), 32'h1);
        step();
        req = '0;
        step();

        // Asynchronous reset in the middle of OUTPUT
        req       = 4'b0100;
        out_ready = 1'b0;
        step();
        step();
        check("ar_pre_valid", 32'(out_valid), 32'h1);
        #3;
        resetn = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_dout",  32'(dout),      32'h0);
        check("ar_owner", 32'(owner),     32'h0);
        check("ar_ack",   32'(ack),       32'h0);
        req       = 4'b0011;
        out_ready = 1'b1;
        #3;
        resetn = 1'b1;
        step();
        check("ar_next_ack", 32'(ack), 32'h1);
        step();
        check("ar_next_owner", 32'(owner),     32'h0);
        check("ar_next_dout",  32'(dout),      32'h10);
        check("ar_next_valid", 32'(out_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dff_rr_capture_arb
`default_nettype wire
